smiley_obstacle_collision: RTL and testbench

//  Upstream stage of the smiley motion controller. Watches smiley and obstacle

---
 rtl/smiley_obstacle_collision.sv | 145 ++++++++++++++
 tb/tb_smiley_obstacle_collision.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smiley_obstacle_collision.sv
// Smiley/obstacle overlap classifier: a two-stage pipeline feeding a per-frame FSM that emits one debounced collision pulse and an edge code.
// Optional feature: define SMILEY_COLLISION_CORNER_EN so that corner pixels set both their horizontal and vertical edge bits.
module smiley_obstacle_collision #(
  parameter int OBJECT_WIDTH       = 32,
  parameter int OBJECT_HEIGHT      = 32,
  parameter int EDGE_DEPTH         = 4,
  parameter int MIN_OVERLAP_PIXELS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        smileyDrawingRequest,
  input  logic        obstacleDrawingRequest,
  output logic        collisionSmileyObstacle,
  output logic [3:0]  hitEdgeCode,
  output logic [7:0]  overlapCount
);

  localparam logic signed [11:0] LP_W   = 12'(OBJECT_WIDTH);
  localparam logic signed [11:0] LP_H   = 12'(OBJECT_HEIGHT);
  localparam logic signed [11:0] LP_D   = 12'(EDGE_DEPTH);
  localparam logic signed [11:0] LP_RX  = 12'(OBJECT_WIDTH - EDGE_DEPTH);
  localparam logic signed [11:0] LP_BY  = 12'(OBJECT_HEIGHT - EDGE_DEPTH);
  localparam logic [7:0]         LP_MIN = 8'(MIN_OVERLAP_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORTED} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic signed [11:0] w_off_x;
  logic signed [11:0] w_off_y;
  logic               w_in_box;
  logic               w_zl, w_zt, w_zr, w_zb;
  logic [3:0]         w_zone;
  logic               w_edge_hit;
  logic               r_edge;
  logic [3:0]         r_zone;
  logic [7:0]         r_count;
  logic [3:0]         r_edge_acc;
  logic               r_trig;
  logic               r_pulse;
  logic [3:0]         r_code;
  logic [7:0]         w_cnt_inc;
  logic               w_reach;
  logic               w_adv;
  logic               w_trig_set;

  // Sign-extend to 12 bits so off-screen positions compare without wrap-around.
  assign w_off_x  = $signed({pixelX[10], pixelX}) - $signed({topLeftX[10], topLeftX});
  assign w_off_y  = $signed({pixelY[10], pixelY}) - $signed({topLeftY[10], topLeftY});
  assign w_in_box = (w_off_x >= 12'sd0) && (w_off_x < LP_W) &&
                    (w_off_y >= 12'sd0) && (w_off_y < LP_H);
  assign w_zl     = (w_off_x < LP_D);
  assign w_zr     = (w_off_x >= LP_RX);
  assign w_zt     = (w_off_y < LP_D);
  assign w_zb     = (w_off_y >= LP_BY);

`ifdef SMILEY_COLLISION_CORNER_EN
  assign w_zone = {w_zl, w_zt, w_zr, w_zb};
`else
  // Vertical zone wins at corners so the controller bounces on Y only.
  assign w_zone = {w_zl & ~(w_zt | w_zb), w_zt, w_zr & ~(w_zt | w_zb), w_zb};
`endif

  assign w_edge_hit = smileyDrawingRequest & obstacleDrawingRequest & w_in_box & (|w_zone);
  assign w_cnt_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
  assign w_reach    = (w_cnt_inc >= LP_MIN);
  assign w_adv      = r_edge & ~pause & ~startOfFrame;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_trig_set   = 1'b0;
    if (startOfFrame) begin
      w_state_next = S_IDLE;
    end else if (w_adv) begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_reach) begin
            w_state_next = S_REPORTED;
            w_trig_set   = 1'b1;
          end else begin
            w_state_next = S_ACCUM;
          end
        end
        S_REPORTED: w_state_next = S_REPORTED;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge     <= 1'b0;
      r_zone     <= 4'd0;
      r_count    <= 8'd0;
      r_edge_acc <= 4'd0;
      r_trig     <= 1'b0;
      r_pulse    <= 1'b0;
      r_code     <= 4'd0;
    end else begin
      // A paused stage 1 holds its contents so an in-flight hit is not lost.
      if (!pause) begin
        r_edge <= w_edge_hit;
        r_zone <= w_zone;
      end else if (startOfFrame) begin
        r_edge <= 1'b0;
      end
      if (startOfFrame) begin
        r_count    <= 8'd0;
        r_edge_acc <= 4'd0;
        r_trig     <= 1'b0;
        r_pulse    <= 1'b0;
        r_code     <= 4'd0;
      end else begin
        if (w_adv) begin
          r_count    <= w_cnt_inc;
          r_edge_acc <= r_edge_acc | r_zone;
        end
        if (w_trig_set)  r_trig <= 1'b1;
        else if (!pause) r_trig <= 1'b0;
        if (!pause) begin
          r_pulse <= r_trig;
          if (r_trig) r_code <= r_edge_acc;
        end else begin
          r_pulse <= 1'b0;
        end
      end
    end
  end

  assign collisionSmileyObstacle = r_pulse;
  assign hitEdgeCode             = r_code;
  assign overlapCount            = r_count;

endmodule

// File: tb/tb_smiley_obstacle_collision.sv
// Self-checking bench for smiley_obstacle_collision against a frame-level behavioural model.
module tb_smiley_obstacle_collision;

  localparam int W = 32, H = 32, ED = 4, MINP = 3;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, pause;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        smileyDrawingRequest, obstacleDrawingRequest;
  logic        collisionSmileyObstacle;
  logic [3:0]  hitEdgeCode;
  logic [7:0]  overlapCount;

  smiley_obstacle_collision #(
    .OBJECT_WIDTH(W), .OBJECT_HEIGHT(H), .EDGE_DEPTH(ED), .MIN_OVERLAP_PIXELS(MINP)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .smileyDrawingRequest(smileyDrawingRequest), .obstacleDrawingRequest(obstacleDrawingRequest),
    .collisionSmileyObstacle(collisionSmileyObstacle), .hitEdgeCode(hitEdgeCode),
    .overlapCount(overlapCount)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int tl_x = 100, tl_y = 100;

  // Model state: frame-level totals plus the cycle a pending report becomes visible.
  int         cyc = 0, m_count = 0, m_pulse_cyc = -1, exp_count = 0;
  logic [3:0] m_acc = 0, m_pend = 0, exp_code = 0;
  bit         m_rep = 0, exp_pulse = 0;
  int         pulse_bad = 0, count_bad = 0, code_bad = 0, pulses_seen = 0;

  function automatic logic [3:0] zone_of(int px, int py, int tx, int ty);
    int dx, dy;
    bit l, t, r, b;
    dx = px - tx;
    dy = py - ty;
    if (dx < 0 || dx >= W || dy < 0 || dy >= H) return 4'd0;
    l = dx < ED; r = dx >= W - ED; t = dy < ED; b = dy >= H - ED;
`ifndef SMILEY_COLLISION_CORNER_EN
    if (t || b) begin l = 0; r = 0; end
`endif
    return {l, t, r, b};
  endfunction

  task automatic cycle(input bit rst, input bit sof, input bit pse,
                       input int px, input int py, input bit sreq, input bit oreq);
    logic [3:0] z;
    reset = rst; startOfFrame = sof; pause = pse;
    pixelX = 11'(px); pixelY = 11'(py); topLeftX = 11'(tl_x); topLeftY = 11'(tl_y);
    smileyDrawingRequest = sreq; obstacleDrawingRequest = oreq;
    @(posedge clk);
    cyc++;
    exp_pulse = 0;
    if (rst) begin
      m_count = 0; m_acc = 0; m_rep = 0; m_pulse_cyc = -1; exp_code = 0; exp_count = 0;
    end else begin
      if (sof) begin
        m_count = 0; m_acc = 0; m_rep = 0; m_pulse_cyc = -1; exp_code = 0;
      end
      if (m_pulse_cyc == cyc) begin
        exp_pulse = 1; exp_code = m_pend; m_pulse_cyc = -1;
      end
      exp_count = m_count;
      z = zone_of(px, py, tl_x, tl_y);
      if (!pse && sreq && oreq && z != 0) begin
        if (m_count < 255) m_count++;
        m_acc |= z;
        if (!m_rep && m_count >= MINP) begin
          m_rep = 1; m_pulse_cyc = cyc + 2; m_pend = m_acc;
        end
      end
    end
    #1;
    if (collisionSmileyObstacle === 1'b1) pulses_seen++;
    if (collisionSmileyObstacle !== exp_pulse) pulse_bad++;
    if (overlapCount !== 8'(exp_count)) count_bad++;
    if (hitEdgeCode !== exp_code) code_bad++;
    if (sreq && oreq)
      $display("cyc=%0d px=%0d py=%0d sof=%0b pause=%0b rst=%0b count=%0d pulse=%0b code=%b",
               cyc, px, py, sof, pse, rst, overlapCount, collisionSmileyObstacle, hitEdgeCode);
  endtask

  task automatic hit(input int px, input int py);
    cycle(0, 0, 0, px, py, 1, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic new_frame();
    cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_err();
    pulse_bad = 0; count_bad = 0; code_bad = 0; pulses_seen = 0;
  endtask

  task automatic check_model(input string name);
    n_assert++;
    if (pulse_bad + count_bad + code_bad !== 0) begin
      n_fail++;
      $display("FAIL %s model: pulse_err=%0d count_err=%0d code_err=%0d required 0", name, pulse_bad, count_bad, code_bad);
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_assert++;
    if ({collisionSmileyObstacle, hitEdgeCode, overlapCount} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state got pulse=%b code=%b count=%0d required 0", collisionSmileyObstacle, hitEdgeCode, overlapCount);
    end
    clear_err();
    new_frame();
    hit(110, 100); hit(110, 101);
    cycle(1, 0, 0, 110, 102, 1, 1);
    cycle(1, 0, 0, 110, 103, 1, 1);
    n_assert++;
    if ({collisionSmileyObstacle, hitEdgeCode, overlapCount} !== 13'd0) begin
      n_fail++;
      $display("FAIL midframe_reset got pulse=%b code=%b count=%0d required 0", collisionSmileyObstacle, hitEdgeCode, overlapCount);
    end
    idle(5);
    n_assert++;
    if (pulses_seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse got %0d pulses required 0", pulses_seen);
    end
    check_model("reset");
  endtask

  task automatic test_basic();
    clear_err();
    tl_x = 100; tl_y = 100;
    new_frame();
    hit(110, 100); hit(110, 101); hit(110, 102);
    idle(3);
    n_assert++;
    if (pulses_seen !== 1 || hitEdgeCode !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_pulse got pulses=%0d code=%b required 1 and 0100", pulses_seen, hitEdgeCode);
    end
    for (int i = 0; i < 10; i++) hit(110, 100 + (i % 3));
    idle(3);
    n_assert++;
    if (pulses_seen !== 1 || overlapCount !== 8'd13) begin
      n_fail++;
      $display("FAIL basic_continue got pulses=%0d count=%0d required 1 and 13", pulses_seen, overlapCount);
    end
    new_frame();
    n_assert++;
    if (hitEdgeCode !== 4'd0 || overlapCount !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_newframe got code=%b count=%0d required 0", hitEdgeCode, overlapCount);
    end
    check_model("basic");
  endtask

  task automatic test_corner();
    logic [3:0] want;
`ifdef SMILEY_COLLISION_CORNER_EN
    want = 4'b1100;
`else
    want = 4'b0100;
`endif
    clear_err();
    new_frame();
    hit(100, 100); hit(100, 100); hit(100, 100);
    idle(4);
    n_assert++;
    if (hitEdgeCode !== want || pulses_seen !== 1) begin
      n_fail++;
      $display("FAIL corner_code got code=%b pulses=%0d required %b and 1", hitEdgeCode, pulses_seen, want);
    end
    check_model("corner");
  endtask

  task automatic test_pause();
    clear_err();
    new_frame();
    hit(110, 100); hit(110, 101);
    idle(3);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 110, 100, 1, 1);
    cycle(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    n_assert++;
    if (pulses_seen !== 0 || overlapCount !== 8'd2) begin
      n_fail++;
      $display("FAIL pause_frozen got pulses=%0d count=%0d required 0 and 2", pulses_seen, overlapCount);
    end
    hit(110, 102);
    idle(4);
    n_assert++;
    if (pulses_seen !== 1 || overlapCount !== 8'd3) begin
      n_fail++;
      $display("FAIL pause_resume got pulses=%0d count=%0d required 1 and 3", pulses_seen, overlapCount);
    end
    check_model("pause");
  endtask

  task automatic test_sof_hit();
    clear_err();
    new_frame();
    hit(110, 100); hit(110, 101);
    cycle(0, 1, 0, 131, 116, 1, 1);
    idle(2);
    n_assert++;
    if (overlapCount !== 8'd1) begin
      n_fail++;
      $display("FAIL sof_hit_count got %0d required 1", overlapCount);
    end
    hit(131, 116); hit(131, 116);
    idle(4);
    n_assert++;
    if (hitEdgeCode !== 4'b0010 || pulses_seen !== 1) begin
      n_fail++;
      $display("FAIL sof_hit_code got code=%b pulses=%0d required 0010 and 1", hitEdgeCode, pulses_seen);
    end
    check_model("sof_hit");
  endtask

  task automatic test_saturation();
    clear_err();
    new_frame();
    for (int i = 0; i < 300; i++) hit(100 + (i % 32), 130);
    idle(2);
    n_assert++;
    if (overlapCount !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation got %0d required 255", overlapCount);
    end
    check_model("saturation");
  endtask

  task automatic test_back_to_back();
    int px, py;
    clear_err();
    new_frame();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(39) == 0) begin
        tl_x = int'($urandom_range(80)) - 20;
        tl_y = int'($urandom_range(80)) - 20;
        px = tl_x + int'($urandom_range(39)) - 4;
        py = tl_y + int'($urandom_range(39)) - 4;
        cycle(0, 1, 0, px, py, $urandom_range(9) < 7, $urandom_range(9) < 7);
      end else begin
        px = tl_x + int'($urandom_range(39)) - 4;
        py = tl_y + int'($urandom_range(39)) - 4;
        cycle(0, 0, 0, px, py, $urandom_range(9) < 7, $urandom_range(9) < 7);
      end
    end
    idle(3);
    n_assert++;
    if (pulses_seen < 1) begin
      n_fail++;
      $display("FAIL random_activity got %0d pulses required at least 1", pulses_seen);
    end
    check_model("random");
  endtask

  initial begin
    reset = 1; startOfFrame = 0; pause = 0;
    pixelX = 0; pixelY = 0; topLeftX = 0; topLeftY = 0;
    smileyDrawingRequest = 0; obstacleDrawingRequest = 0;
    test_reset();
    test_basic();
    test_corner();
    test_pause();
    test_sof_hit();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
